// File: rtl/serial_adder_fsm.sv
// Bit-serial adder: captures a, b, cin on a rising start edge, adds LSB-first one
// bit per clk_out cycle, then registers the sum and carry for the display stage.
module serial_adder_fsm #(
  parameter int WIDTH = 4
) (
  input  logic             clk_out,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] suma,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic             start_q;
  logic [WIDTH-1:0] aSh_q;
  logic [WIDTH-1:0] bSh_q;
  logic [WIDTH-1:0] resSh_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  logic             trig;
  logic             sumBit_d;
  logic             carry_d;

  // One full-adder slice evaluated on the current LSBs each SHIFT cycle.
  always_comb begin
    trig     = start & ~start_q;
    sumBit_d = aSh_q[0] ^ bSh_q[0] ^ carry_q;
    carry_d  = (aSh_q[0] & bSh_q[0]) | (aSh_q[0] & carry_q) | (bSh_q[0] & carry_q);
  end

  // suma/cout only change in DONE, so the display never sees a partial sum.
  always_ff @(posedge clk_out) begin
    if (reset) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      aSh_q   <= '0;
      bSh_q   <= '0;
      resSh_q <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      suma    <= '0;
      cout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      start_q <= start;
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (trig) begin
            aSh_q   <= a;
            bSh_q   <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= SHIFT;
          end else begin
            busy <= 1'b0;
          end
        end
        SHIFT: begin
          done    <= 1'b0;
          carry_q <= carry_d;
          resSh_q <= {sumBit_d, resSh_q[WIDTH-1:1]};
          aSh_q   <= aSh_q >> 1;
          bSh_q   <= bSh_q >> 1;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          suma    <= resSh_q;
          cout    <= carry_q;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Self-checking bench for serial_adder_fsm: expected {cout,suma} values are queued
// when an operation is started and popped when the done pulse appears.
module tb_serial_adder_fsm;

  logic       clk_out;
  logic       reset;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] suma;
  logic       cout;
  logic       busy;
  logic       done;

  int vectors;
  int miscompares;
  logic [4:0] expQ[$];

  serial_adder_fsm #(.WIDTH(4)) dut (
    .clk_out(clk_out),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .suma   (suma),
    .cout   (cout),
    .busy   (busy),
    .done   (done)
  );

  initial clk_out = 1'b0;
  always #5 clk_out = ~clk_out;

  task automatic tick();
    @(posedge clk_out);
    #1;
  endtask

  // Drives operands with a rising start; the tick inside is edge E0.
  task automatic startOp(input logic [3:0] av, input logic [3:0] bv, input logic cv,
                         input bit expectResult);
    a   = av;
    b   = bv;
    cin = cv;
    start = 1'b1;
    if (expectResult) expQ.push_back(5'(av) + 5'(bv) + 5'(cv));
    tick();
  endtask

  task automatic waitDone(input int firstEdge, output int edges);
    edges = firstEdge;
    while (done !== 1'b1 && edges < firstEdge + 20) begin
      tick();
      edges++;
    end
  endtask

  task automatic popExpected(output logic [4:0] exp, output bit ok);
    ok  = (expQ.size() != 0);
    exp = ok ? expQ.pop_front() : 5'h00;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; a = 4'h0; b = 4'h0; cin = 1'b0;
    tick(); tick();
    vectors++;
    if ({suma, cout, busy, done} !== 7'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got suma=%0d cout=%0b busy=%0b done=%0b, want all 0",
               suma, cout, busy, done);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int edges; logic [4:0] exp; bit ok;
    startOp(4'd3, 4'd4, 1'b0, 1'b1);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL t1_busy_after_e0: got %0b, want 1", busy);
    end
    start = 1'b0;
    tick();
    tick();
    vectors++;
    if ({cout, suma} !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL t1_hold_prev: got %0d, want 0 during operation", {cout, suma});
    end
    waitDone(2, edges);
    vectors++;
    if (edges != 5) begin
      miscompares++;
      $display("[TB] FAIL t1_latency: got %0d edges, want 5", edges);
    end
    popExpected(exp, ok);
    vectors++;
    if (!ok || {cout, suma} !== exp) begin
      miscompares++;
      $display("[TB] FAIL t1_result: got %0d, want %0d (queue ok=%0b)", {cout, suma}, exp, ok);
    end
    tick();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL t1_pulse_end: got done=%0b busy=%0b, want 0 0", done, busy);
    end
  endtask

  task automatic test_overflow();
    int edges; logic [4:0] exp; bit ok;
    logic [3:0] opA[2] = '{4'd15, 4'd15};
    logic [3:0] opB[2] = '{4'd1, 4'd15};
    logic       opC[2] = '{1'b0, 1'b1};
    logic [4:0] want[2] = '{5'b1_0000, 5'b1_1111};
    for (int i = 0; i < 2; i++) begin
      startOp(opA[i], opB[i], opC[i], 1'b1);
      start = 1'b0;
      waitDone(0, edges);
      popExpected(exp, ok);
      vectors++;
      if (!ok || {cout, suma} !== exp || exp !== want[i]) begin
        miscompares++;
        $display("[TB] FAIL t2_overflow_%0d: got %0d, want %0d", i, {cout, suma}, want[i]);
      end
      tick();
    end
  endtask

  task automatic test_held_start();
    int pulses; logic [4:0] exp; logic [4:0] held; bit ok;
    pulses = 0; held = 5'h00;
    startOp(4'd6, 4'd9, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done === 1'b1) begin
        pulses++;
        popExpected(exp, ok);
        held = {cout, suma};
        vectors++;
        if (!ok || {cout, suma} !== exp) begin
          miscompares++;
          $display("[TB] FAIL t3_result: got %0d, want %0d", {cout, suma}, exp);
        end
      end
    end
    vectors++;
    if (pulses != 1) begin
      miscompares++;
      $display("[TB] FAIL t3_pulse_count: got %0d, want 1", pulses);
    end
    vectors++;
    if ({cout, suma} !== held || held !== 5'd16) begin
      miscompares++;
      $display("[TB] FAIL t3_stable: got %0d, want 16", {cout, suma});
    end
    start = 1'b0;
    tick();
  endtask

  task automatic test_ignored_inputs();
    int edges; int extra; logic [4:0] exp; bit ok;
    startOp(4'd5, 4'd6, 1'b0, 1'b1);
    a = 4'd1; b = 4'd1; cin = 1'b1; start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    waitDone(2, edges);
    vectors++;
    if (edges != 5) begin
      miscompares++;
      $display("[TB] FAIL t4_latency: got %0d edges, want 5", edges);
    end
    popExpected(exp, ok);
    vectors++;
    if (!ok || {cout, suma} !== exp) begin
      miscompares++;
      $display("[TB] FAIL t4_result: got %0d, want %0d", {cout, suma}, exp);
    end
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done === 1'b1) extra++;
    end
    vectors++;
    if (extra != 0) begin
      miscompares++;
      $display("[TB] FAIL t4_no_requeue: got %0d extra done pulses, want 0", extra);
    end
  endtask

  task automatic test_reset_mid_op();
    int edges; int pulses; logic [4:0] exp; bit ok;
    startOp(4'd4, 4'd5, 1'b0, 1'b1);
    start = 1'b0;
    waitDone(0, edges);
    popExpected(exp, ok);
    vectors++;
    if (!ok || {cout, suma} !== exp) begin
      miscompares++;
      $display("[TB] FAIL t5_prior: got %0d, want %0d", {cout, suma}, exp);
    end
    tick();
    startOp(4'd7, 4'd7, 1'b0, 1'b0);
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if ({suma, cout, busy, done} !== 7'b0) begin
      miscompares++;
      $display("[TB] FAIL t5_abort: got suma=%0d cout=%0b busy=%0b done=%0b, want all 0",
               suma, cout, busy, done);
    end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    vectors++;
    if (pulses != 0 || suma !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL t5_no_done: got %0d pulses suma=%0d, want 0 and 0", pulses, suma);
    end
    startOp(4'd2, 4'd2, 1'b0, 1'b1);
    start = 1'b0;
    waitDone(0, edges);
    popExpected(exp, ok);
    vectors++;
    if (!ok || {cout, suma} !== exp || edges != 5) begin
      miscompares++;
      $display("[TB] FAIL t5_restart: got %0d after %0d edges, want %0d after 5",
               {cout, suma}, edges, exp);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int edges; logic [4:0] exp; bit ok;
    startOp(4'd9, 4'd8, 1'b0, 1'b1);
    start = 1'b0;
    waitDone(0, edges);
    popExpected(exp, ok);
    vectors++;
    if (!ok || {cout, suma} !== exp) begin
      miscompares++;
      $display("[TB] FAIL b2b_first: got %0d, want %0d", {cout, suma}, exp);
    end
    startOp(4'd10, 4'd3, 1'b1, 1'b1);
    start = 1'b0;
    waitDone(0, edges);
    popExpected(exp, ok);
    vectors++;
    if (!ok || {cout, suma} !== exp || edges != 5) begin
      miscompares++;
      $display("[TB] FAIL b2b_second: got %0d after %0d edges, want %0d after 5",
               {cout, suma}, edges, exp);
    end
    tick();
  endtask

  task automatic test_exhaustive();
    int edges; logic [4:0] exp; bit ok;
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          startOp(4'(ai), 4'(bi), 1'(ci), 1'b1);
          start = 1'b0;
          waitDone(0, edges);
          popExpected(exp, ok);
          vectors++;
          if (!ok || {cout, suma} !== exp || edges != 5) begin
            miscompares++;
            $display("[TB] FAIL t6_%0d_%0d_%0d: got %0d after %0d edges, want %0d after 5",
                     ai, bi, ci, {cout, suma}, edges, exp);
          end
        end
      end
    end
    tick();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_overflow();
    test_held_start();
    test_ignored_inputs();
    test_reset_mid_op();
    test_back_to_back();
    test_exhaustive();
    vectors++;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, want 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
